// File: rtl/tri_state_buffer_1bit.sv
// Single-bit tri-state bus driver with a registered enable and optional drive statistics.
// Define TRISTATE_STATS_EN to build the drive/toggle counters; otherwise they read 0.
module tri_state_buffer_1bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        sel,
    output tri          dout,
    output logic        oe_q,
    output logic [15:0] drive_cnt,
    output logic [15:0] toggle_cnt
);

    // An unknown enable merges din with Z, so the pin resolves to X.
    assign dout = sel ? din : 1'bz;

    always_ff @(posedge clk) begin
        if (!rst_n) oe_q <= 1'b0;
        else        oe_q <= sel;
    end

`ifdef TRISTATE_STATS_EN
    logic din_q;
    logic prev_drv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drive_cnt  <= 16'h0000;
            toggle_cnt <= 16'h0000;
            din_q      <= 1'b0;
            prev_drv   <= 1'b0;
        end else begin
            if (sel && drive_cnt != 16'hFFFF)
                drive_cnt <= drive_cnt + 16'd1;
            // Only back-to-back driven cycles can count as a toggle.
            if (sel && prev_drv && din != din_q && toggle_cnt != 16'hFFFF)
                toggle_cnt <= toggle_cnt + 16'd1;
            if (sel)
                din_q <= din;
            prev_drv <= sel;
        end
    end
`else
    assign drive_cnt  = 16'h0000;
    assign toggle_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_tri_state_buffer_1bit.sv
// Directed and random bench for tri_state_buffer_1bit against a cycle-level reference model.
module tb_tri_state_buffer_1bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic        sel;
    logic        oe_q;
    logic [15:0] drive_cnt;
    logic [15:0] toggle_cnt;
    tri          dout_w;

    // Opposing bus agent: drives ~din whenever the DUT should be released.
    logic tb_en;
    logic tb_val;
    assign dout_w = tb_en ? tb_val : 1'bz;

    int errors = 0;
    int checks = 0;

`ifdef TRISTATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Reference model state
    int unsigned m_drive;
    int unsigned m_tog;
    bit          m_oe;
    bit          m_prev;
    bit          m_last;

    tri_state_buffer_1bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .sel        (sel),
        .dout       (dout_w),
        .oe_q       (oe_q),
        .drive_cnt  (drive_cnt),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit d, input bit s, input bit r);
        if (!r) begin
            m_drive = 0; m_tog = 0; m_oe = 0; m_prev = 0; m_last = 0;
        end else begin
            if (s) begin
                if (m_prev && d != m_last && m_tog < 65535) m_tog++;
                if (m_drive < 65535) m_drive++;
                m_last = d;
            end
            m_prev = s;
            m_oe   = s;
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input bit d, input bit s, input bit r);
        din = d; sel = s; rst_n = r;
        tb_en = ~s; tb_val = ~d;
        #1;
        chk("dout", {15'd0, dout_w}, {15'd0, (s ? d : ~d)});
        @(posedge clk);
        model_edge(d, s, r);
        @(negedge clk);
        chk("oe_q", {15'd0, oe_q}, {15'd0, m_oe});
        chk("drive_cnt", drive_cnt, STATS ? 16'(m_drive) : 16'h0000);
        chk("toggle_cnt", toggle_cnt, STATS ? 16'(m_tog) : 16'h0000);
    endtask

    initial begin
        logic [15:0] tog_before;
        bit          pat [5];
        din = 1'b0; sel = 1'b0; rst_n = 1'b0; tb_en = 1'b1; tb_val = 1'b1;
        m_drive = 0; m_tog = 0; m_oe = 0; m_prev = 0; m_last = 0;
        @(negedge clk);
        step(0, 0, 0);
        step(0, 0, 0);

        // Released bus never counts
        step(0, 0, 1);
        step(1, 0, 1);
        chk("idle_drive", drive_cnt, 16'h0000);

        // Enable/release sequence, then din change without an edge
        step(0, 1, 1);
        step(1, 0, 1);
        step(1, 1, 1);
        din = 1'b0; #1;
        chk("dout_comb", {15'd0, dout_w}, 16'h0000);
        sel = 1'b0; tb_en = 1'b1; tb_val = 1'b1; #1;
        chk("dout_rel_mid", {15'd0, dout_w}, 16'h0001);
        sel = 1'b1; tb_en = 1'b0; #1;

        // Pattern 0,1,1,0,1 from a clean reset: 5 drives, 3 toggles
        step(0, 0, 0);
        pat = '{0, 1, 1, 0, 1};
        foreach (pat[i]) step(pat[i], 1, 1);
        chk("pat_drive", drive_cnt, STATS ? 16'd5 : 16'd0);
        chk("pat_toggle", toggle_cnt, STATS ? 16'd3 : 16'd0);
        chk("pat_oe", {15'd0, oe_q}, 16'h0001);

        // Reset pulse while driving: pin keeps driving, status clears
        step(1, 1, 0);
        chk("rst_oe", {15'd0, oe_q}, 16'h0000);
        chk("rst_drive", drive_cnt, 16'h0000);
        chk("rst_toggle", toggle_cnt, 16'h0000);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(40) != 0));

        // Release between drives masks the toggle
        step(0, 1, 1);
        tog_before = toggle_cnt;
        step(0, 0, 1);
        step(1, 1, 1);
        chk("release_no_toggle", toggle_cnt, tog_before);

        // Saturation
        step(0, 0, 0);
        for (int i = 0; i < 65540; i++) step(1, 1, 1);
        chk("sat_drive", drive_cnt, STATS ? 16'hFFFF : 16'h0000);
        step(0, 1, 1);
        chk("sat_hold", drive_cnt, STATS ? 16'hFFFF : 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
